// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter.
// x0/f0 are hard-wired zero, so they are never tracked or written.
package wb_pkg;
  localparam int NUM_REGS = 64;
  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_FPU  = 2;

  typedef struct packed {
    logic       en;
    logic [5:0] rd;
  } wb_port_t;

  function automatic logic is_zero_reg(input logic [5:0] rd);
    return rd[4:0] == 5'd0;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Producer, issue-stage and register-file signals of the write-back arbiter.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
);
  logic [NSRC-1:0]              src_valid;
  logic [NSRC-1:0]              src_ready;
  logic [NSRC-1:0][REG_AW-1:0]  src_rd;
  logic [NSRC-1:0][DATA_W-1:0]  src_data;
  logic                         iss_valid;
  logic [REG_AW-1:0]            iss_rd;
  logic                         iss_ready;
  logic [NUM_REGS-1:0]          busy;
  logic [REG_AW:0]              wb_rd;
  logic [DATA_W-1:0]            rddata;

  modport master (
    output src_valid, src_rd, src_data, iss_valid, iss_rd,
    input  src_ready, iss_ready, busy, wb_rd, rddata
  );

  modport slave (
    input  src_valid, src_rd, src_data, iss_valid, iss_rd,
    output src_ready, iss_ready, busy, wb_rd, rddata
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Pointer resets to N-1 so index 0 has top priority out of reset.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gidx   = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= PW'(N - 1);
    else if (advance) ptr <= gidx;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one producer result per cycle, registers the
// register-file write, and tracks per-register outstanding writes.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int STAGES = 1;

  logic [NSRC-1:0]     gnt;
  logic [NSRC-1:0]     hs_vec;
  logic                hs;
  logic [STAGES:1]     vld_q;
  logic [STAGES:0]     vld_pipe;
  logic [REG_AW-1:0]   g_rd;
  logic [DATA_W-1:0]   g_data;
  wb_port_t            wb_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REGS-1:0] busy_q;
  logic                claim_ok;

  rr_arbiter #(.N(NSRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.src_valid),
    .advance (hs),
    .gnt     (gnt)
  );

  // No handshake while in reset: in-flight results are dropped, not accepted.
  assign hs_vec        = gnt & {NSRC{~rst}};
  assign hs            = |hs_vec;
  assign vld_pipe      = {vld_q, hs};
  assign bus.src_ready = hs_vec;

  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hs_vec[i]) begin
        g_rd   = g_rd   | bus.src_rd[i];
        g_data = g_data | bus.src_data[i];
      end
    end
  end

  assign claim_ok      = bus.iss_valid & ~busy_q[bus.iss_rd] & ~rst;
  assign bus.iss_ready = claim_ok;
  assign bus.busy      = busy_q;
  assign bus.wb_rd     = {wb_q.en & vld_pipe[STAGES], wb_q.rd};
  assign bus.rddata    = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      wb_q   <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      vld_q  <= vld_pipe[STAGES-1:0];
      wb_q   <= '0;
      data_q <= '0;
      if (hs) begin
        wb_q.en <= !is_zero_reg(g_rd);
        wb_q.rd <= g_rd;
        data_q  <= g_data;
      end
      if (claim_ok && !is_zero_reg(bus.iss_rd)) busy_q[bus.iss_rd] <= 1'b1;
      // Clear wins; a same-register claim this cycle was already refused.
      if (hs) busy_q[g_rd] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes expected writes,
// a negedge monitor matches grants and register-file writes against them.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NSRC(3), .DATA_W(32), .REG_AW(6)) bus ();

  logic [2:0]       src_valid = '0;
  logic [2:0][5:0]  src_rd    = '0;
  logic [2:0][31:0] src_data  = '0;
  logic             iss_valid = 1'b0;
  logic [5:0]       iss_rd    = '0;

  assign bus.src_valid = src_valid;
  assign bus.src_rd    = src_rd;
  assign bus.src_data  = src_data;
  assign bus.iss_valid = iss_valid;
  assign bus.iss_rd    = iss_rd;

  wb_arbiter #(.NSRC(3), .DATA_W(32), .REG_AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          src;
    logic [6:0]  wb;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input logic [6:0] wb, input logic [31:0] d);
    exp_t e;
    e.src = s; e.wb = wb; e.data = d;
    q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic claim(input logic [5:0] rd, input logic exp);
    iss_valid = 1'b1;
    iss_rd    = rd;
    @(negedge clk);
    chk("iss_ready", 64'(bus.iss_ready), 64'(exp));
    step();
    iss_valid = 1'b0;
  endtask

  // Present several sources at once; each drops valid after its handshake.
  task automatic drive(input logic [2:0] m, input logic [2:0][5:0] rd, input logic [2:0][31:0] d);
    logic [2:0] got;
    int n;
    for (int s = 0; s < 3; s++) if (m[s]) begin src_rd[s] = rd[s]; src_data[s] = d[s]; end
    src_valid = m;
    n = 0;
    while (src_valid != 0 && n < 50) begin
      @(negedge clk);
      got = src_valid & bus.src_ready;
      step();
      src_valid = src_valid & ~got;
      n++;
    end
    if (src_valid != 0) begin
      failures++;
      $display("FAIL drive_timeout act=%b exp=000", src_valid);
      src_valid = '0;
    end
  endtask

  // Monitor
  initial begin
    exp_t       pend;
    logic       have_pend;
    logic [2:0] hsv, pv, pr;
    logic [2:0][5:0]  prd;
    logic [2:0][31:0] pd;
    logic [5:0] grd;
    have_pend = 1'b0;
    pv = '0; pr = '0; prd = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_pend = 1'b0;
        pv = '0;
      end else begin
        if (have_pend) begin
          chk("wb_rd", 64'(bus.wb_rd), 64'(pend.wb));
          chk("rddata", 64'(bus.rddata), 64'(pend.data));
          have_pend = 1'b0;
        end else begin
          chk("idle_wb_rd", 64'(bus.wb_rd), 64'h0);
          chk("idle_rddata", 64'(bus.rddata), 64'h0);
        end
        hsv = src_valid & bus.src_ready;
        if (bus.src_ready != 0 && !$onehot(bus.src_ready & src_valid)) begin
          failures++;
          $display("FAIL ready_onehot act=%b valid=%b", bus.src_ready, src_valid);
        end
        if (hsv != 0) begin
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant act=%b exp=none", hsv);
          end else begin
            pend = q.pop_front();
            chk("grant", 64'(hsv), 64'(3'b001 << pend.src));
            grd = src_rd[pend.src];
            if (!bus.busy[grd] && grd[4:0] != 5'd0) begin
              failures++;
              $display("FAIL protocol_not_busy act=0 exp=1 rd=%0d", grd);
            end
            have_pend = 1'b1;
          end
        end
        for (int s = 0; s < 3; s++) begin
          if (pv[s] && !pr[s] && (!src_valid[s] || src_rd[s] != prd[s] || src_data[s] != pd[s])) begin
            failures++;
            $display("FAIL hold_stable src=%0d act=%h exp=%h", s, src_data[s], pd[s]);
          end
        end
        pv = src_valid; pr = bus.src_ready; prd = src_rd; pd = src_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("rst_busy", bus.busy, 64'h0);
      chk("rst_ready", 64'(bus.src_ready), 64'h0);
      chk("rst_wb_rd", 64'(bus.wb_rd), 64'h0);
    end
    step();

    // Single ALU write
    claim(6'd5, 1'b1);
    @(negedge clk); chk("busy5_set", 64'(bus.busy[5]), 64'h1);
    step();
    push(0, 7'h45, 32'h1234);
    drive(3'b001, {6'd0, 6'd0, 6'd5}, {32'h0, 32'h0, 32'h1234});
    @(negedge clk); chk("busy5_clr", 64'(bus.busy[5]), 64'h0);
    step();

    // Round-robin from reset
    rst = 1'b1; step(); rst = 1'b0;
    claim(6'd1, 1'b1); claim(6'd2, 1'b1); claim(6'd3, 1'b1);
    push(0, 7'h41, 32'hA1); push(1, 7'h42, 32'hA2); push(2, 7'h43, 32'hA3);
    drive(3'b111, {6'd3, 6'd2, 6'd1}, {32'hA3, 32'hA2, 32'hA1});
    @(negedge clk); chk("rr_busy_clr", 64'(bus.busy[3:1]), 64'h0);
    step();

    // Zero register
    claim(6'd32, 1'b1);
    @(negedge clk); chk("busy32_claim", 64'(bus.busy[32]), 64'h0);
    step();
    push(2, 7'h20, 32'hdeadbeef);
    drive(3'b100, {6'd32, 6'd0, 6'd0}, {32'hdeadbeef, 32'h0, 32'h0});
    @(negedge clk); chk("busy32_after", 64'(bus.busy[32]), 64'h0);
    step();

    // Hazard stall with same-cycle claim and clear
    claim(6'd40, 1'b1);
    @(negedge clk); chk("busy40_set", 64'(bus.busy[40]), 64'h1);
    step();
    iss_valid = 1'b1; iss_rd = 6'd40;
    @(negedge clk); chk("stall0", 64'(bus.iss_ready), 64'h0);
    step();
    @(negedge clk); chk("stall1", 64'(bus.iss_ready), 64'h0);
    step();
    src_rd[1] = 6'd40; src_data[1] = 32'h4040; src_valid = 3'b010;
    push(1, 7'h68, 32'h4040);
    @(negedge clk);
    chk("stall_same", 64'(bus.iss_ready), 64'h0);
    chk("mem_ready", 64'(bus.src_ready), 64'h2);
    step();
    src_valid = '0;
    @(negedge clk);
    chk("busy40_clr", 64'(bus.busy[40]), 64'h0);
    chk("retry_ready", 64'(bus.iss_ready), 64'h1);
    step();
    iss_valid = 1'b0;
    @(negedge clk); chk("busy40_reset", 64'(bus.busy[40]), 64'h1);
    step();
    push(1, 7'h68, 32'h5555);
    drive(3'b010, {6'd0, 6'd40, 6'd0}, {32'h0, 32'h5555, 32'h0});

    // Reset mid-operation; ALU write first leaves the pointer at ALU
    claim(6'd11, 1'b1);
    claim(6'd7, 1'b1);
    push(0, 7'h4b, 32'h1111);
    drive(3'b001, {6'd0, 6'd0, 6'd11}, {32'h0, 32'h0, 32'h1111});
    @(negedge clk); chk("busy7_set", 64'(bus.busy[7]), 64'h1);
    step();
    rst = 1'b1;
    src_rd[1] = 6'd7; src_data[1] = 32'h7777; src_valid = 3'b010;
    @(negedge clk); chk("rst_mid_ready", 64'(bus.src_ready), 64'h0);
    step();
    rst = 1'b0; src_valid = '0;
    @(negedge clk);
    chk("rst_mid_busy", bus.busy, 64'h0);
    chk("rst_mid_wb", 64'(bus.wb_rd), 64'h0);
    step();
    claim(6'd9, 1'b1); claim(6'd10, 1'b1);
    push(0, 7'h49, 32'h9999); push(1, 7'h4a, 32'haaaa);
    drive(3'b011, {6'd0, 6'd10, 6'd9}, {32'h0, 32'haaaa, 32'h9999});

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);
    chk("final_busy", bus.busy, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
